// File: rtl/fir_feeder_pkg.sv
// Shared types and defaults for the FIR sample feeder.
// Holds the pacing FSM state encoding and a saturating counter helper.
package fir_feeder_pkg;

   localparam int SAMPLE_W           = 16;
   localparam int DEFAULT_SAMPLE_DIV = 1134;
   localparam int DEFAULT_DEPTH      = 16;
   localparam int DEFAULT_CNT_W      = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_RFD = 2'd2
   } feeder_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with registered pointers and occupancy count.
// Push is ignored when full and pop is ignored when empty; there is no bypass path.
module fir_sample_fifo #(
   parameter int SAMPLE_W = fir_feeder_pkg::SAMPLE_W,
   parameter int DEPTH    = fir_feeder_pkg::DEFAULT_DEPTH
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_push,
   input  logic [SAMPLE_W-1:0] i_push_data,
   input  logic                i_pop,
   output logic                o_full,
   output logic                o_empty,
   output logic [SAMPLE_W-1:0] o_head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [SAMPLE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic                w_push;
   logic                w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage is not reset; validity is tracked entirely by r_count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces buffered audio samples into the FIR din/rfd port, one per sample period.
// Build option FEEDER_HOLD_LAST_EN: on underrun repeat the last emitted sample instead of 0.
//
// state    | meaning
// IDLE     | pacing stopped, tick counter held at 0
// RUN      | counting the sample period, emit on tick when rfd is high
// WAIT_RFD | a tick is pending, emit on the first cycle rfd is high
module fir_sample_feeder #(
   parameter int SAMPLE_W   = fir_feeder_pkg::SAMPLE_W,
   parameter int DEPTH      = fir_feeder_pkg::DEFAULT_DEPTH,
   parameter int SAMPLE_DIV = fir_feeder_pkg::DEFAULT_SAMPLE_DIV,
   parameter int CNT_W      = fir_feeder_pkg::DEFAULT_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                rfd,
   output logic [SAMPLE_W-1:0] din,
   output logic                din_valid,
   output logic                underrun,
   output logic                late,
   output logic [CNT_W-1:0]    samples_sent,
   output logic [15:0]         underrun_cnt
);

   import fir_feeder_pkg::*;

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   feeder_state_t       r_state;
   feeder_state_t       w_state_nxt;
   logic [DIV_W-1:0]    r_count;
   logic [DIV_W-1:0]    w_count_nxt;
   logic                w_tick;
   logic                w_emit;
   logic                w_set_late;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic [SAMPLE_W-1:0] w_head;

   logic [SAMPLE_W-1:0] r_din;
   logic                r_din_valid;
   logic                r_underrun;
   logic                r_late;
   logic [CNT_W-1:0]    r_samples_sent;
   logic [15:0]         r_underrun_cnt;

   assign s_ready = !w_full && !rst;
   assign w_push  = s_valid && s_ready;
   assign w_tick  = (r_state != IDLE) && (r_count == DIV_LAST);

   fir_sample_fifo #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_push      (w_push),
      .i_push_data (s_data),
      .i_pop       (w_emit),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_emit      = 1'b0;
      w_set_late  = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = RUN;
               w_count_nxt = '0;
            end
            RUN: begin
               w_count_nxt = w_tick ? '0 : r_count + DIV_W'(1);
               if (w_tick) begin
                  if (rfd) begin
                     w_emit = 1'b1;
                  end else begin
                     w_state_nxt = WAIT_RFD;
                  end
               end
            end
            WAIT_RFD: begin
               // A second tick while waiting merges into the pending emit.
               w_count_nxt = w_tick ? '0 : r_count + DIV_W'(1);
               w_set_late  = w_tick;
               if (rfd) begin
                  w_emit      = 1'b1;
                  w_state_nxt = RUN;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_din          <= '0;
         r_din_valid    <= 1'b0;
         r_underrun     <= 1'b0;
         r_late         <= 1'b0;
         r_samples_sent <= '0;
         r_underrun_cnt <= '0;
      end else begin
         r_din_valid <= w_emit;
         r_late      <= r_late | w_set_late;
         if (w_emit) begin
            r_samples_sent <= r_samples_sent + CNT_W'(1);
            if (!w_empty) begin
               r_din <= w_head;
            end else begin
               r_underrun     <= 1'b1;
               r_underrun_cnt <= sat_inc16(r_underrun_cnt);
`ifdef FEEDER_HOLD_LAST_EN
               r_din          <= r_din;
`else
               r_din          <= '0;
`endif
            end
         end
      end
   end

   assign din          = r_din;
   assign din_valid    = r_din_valid;
   assign underrun     = r_underrun;
   assign late         = r_late;
   assign samples_sent = r_samples_sent;
   assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_fir_sample_feeder;

   localparam int SW    = 16;
   localparam int DEPTH = 16;
   localparam int DIV   = 8;
   localparam int CW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [SW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          rfd;
   logic [SW-1:0] din;
   logic          din_valid;
   logic          underrun;
   logic          late;
   logic [CW-1:0] samples_sent;
   logic [15:0]   underrun_cnt;

   always #5 clk = ~clk;

   fir_sample_feeder #(
      .SAMPLE_W   (SW),
      .DEPTH      (DEPTH),
      .SAMPLE_DIV (DIV),
      .CNT_W      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .rfd          (rfd),
      .din          (din),
      .din_valid    (din_valid),
      .underrun     (underrun),
      .late         (late),
      .samples_sent (samples_sent),
      .underrun_cnt (underrun_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: sample queue, cycles-since-start phase, pending-tick flag.
   logic [SW-1:0] m_q[$];
   bit            m_running = 1'b0;
   bit            m_pending = 1'b0;
   int            m_phase   = 0;
   logic [SW-1:0] m_din     = '0;
   bit            m_dv      = 1'b0;
   bit            m_underrun = 1'b0;
   bit            m_late    = 1'b0;
   logic [CW-1:0] m_sent    = '0;
   logic [15:0]   m_ucnt    = '0;
   bit            m_pushed  = 1'b0;

   // Called just after a negedge: drive inputs, advance model across the posedge, compare.
   task automatic step(input bit r, input bit en, input logic [SW-1:0] d, input bit v, input bit rf);
      bit push;
      bit tick;
      bit emit;
      rst = r; enable = en; s_data = d; s_valid = v; rfd = rf;
      #1;
      check_val("s_ready", 32'(s_ready), 32'(!r && (m_q.size() < DEPTH)));
      push = 1'b0;
      emit = 1'b0;
      if (r) begin
         m_q.delete();
         m_running = 1'b0; m_pending = 1'b0; m_phase = 0;
         m_din = '0; m_dv = 1'b0; m_underrun = 1'b0; m_late = 1'b0;
         m_sent = '0; m_ucnt = '0;
      end else begin
         push = v && (m_q.size() < DEPTH);
         if (!en) begin
            m_running = 1'b0; m_pending = 1'b0; m_phase = 0;
         end else if (!m_running) begin
            m_running = 1'b1; m_phase = 0;
         end else begin
            tick = ((m_phase % DIV) == DIV - 1);
            m_phase++;
            if (m_pending) begin
               if (tick) m_late = 1'b1;
               if (rf) begin emit = 1'b1; m_pending = 1'b0; end
            end else if (tick) begin
               if (rf) emit = 1'b1;
               else m_pending = 1'b1;
            end
         end
         m_dv = emit;
         if (emit) begin
            m_sent = m_sent + 1;
            if (m_q.size() > 0) begin
               m_din = m_q.pop_front();
            end else begin
               m_underrun = 1'b1;
               if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
`ifdef FEEDER_HOLD_LAST_EN
               m_din = m_din;
`else
               m_din = '0;
`endif
            end
         end
         if (push) m_q.push_back(d);
      end
      m_pushed = push;
      @(posedge clk);
      @(negedge clk);
      check_val("din_valid", 32'(din_valid), 32'(m_dv));
      check_val("din", 32'(din), 32'(m_din));
      check_val("underrun", 32'(underrun), 32'(m_underrun));
      check_val("late", 32'(late), 32'(m_late));
      check_val("samples_sent", samples_sent, m_sent);
      check_val("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
   endtask

   initial begin
      int first;
      int nstr;
      int acc;
      bit en_r;
      rst = 1'b1; enable = 1'b0; s_data = '0; s_valid = 1'b0; rfd = 1'b1;
      @(negedge clk);
      repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      check_val("reset_sent", samples_sent, 32'd0);
      check_val("reset_din", 32'(din), 32'd0);

      // Paced delivery of four queued samples
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 16'(i), 1'b1, 1'b1);
      first = -1; nstr = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
         if (din_valid) begin
            if (first < 0) first = i;
            nstr++;
            check_val("t1_din_seq", 32'(din), 32'(nstr));
         end
      end
      check_val("t1_first_strobe", 32'(first), 32'd9);
      check_val("t1_sent", samples_sent, 32'd4);

      // Underrun after one real sample
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h1234, 1'b1, 1'b1);
      for (int i = 1; i <= 33; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
      check_val("t2_ucnt", 32'(underrun_cnt), 32'd3);
      check_val("t2_underrun", 32'(underrun), 32'd1);
`ifdef FEEDER_HOLD_LAST_EN
      check_val("t2_din_hold", 32'(din), 32'h1234);
`else
      check_val("t2_din_zero", 32'(din), 32'h0);
`endif

      // Fill to full, 17th accepted only after the first pop
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i <= 16; i++) step(1'b0, 1'b0, 16'h100 + 16'(i), 1'b1, 1'b1);
      check_val("t3_full", 32'(s_ready), 32'd0);
      acc = -1;
      for (int i = 1; i <= 30; i++) begin
         step(1'b0, 1'b1, 16'h110, 1'b1, 1'b1);
         if (m_pushed) begin acc = i; break; end
      end
      check_val("t3_accept_cycle", 32'(acc), 32'd10);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);

      // rfd stall: short wait, then two merged ticks
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h200 + 16'(i), 1'b1, 1'b1);
      first = -1;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b1, 16'h0, 1'b0, (i == 12));
         if (din_valid && first < 0) first = i;
      end
      check_val("t4_strobe_after_rfd", 32'(first), 32'd12);
      check_val("t4_no_late", 32'(late), 32'd0);
      nstr = 0;
      for (int i = 13; i <= 31; i++) begin
         step(1'b0, 1'b1, 16'h0, 1'b0, (i == 31));
         if (din_valid) nstr++;
      end
      check_val("t4_merged_strobes", 32'(nstr), 32'd1);
      check_val("t4_late", 32'(late), 32'd1);

      // Reset mid-run discards queued samples
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h500 + 16'(i), 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
      check_val("t5_rst_sent", samples_sent, 32'd0);
      check_val("t5_rst_dv", 32'(din_valid), 32'd0);
      nstr = 0;
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
         if (din_valid) nstr++;
      end
      check_val("t5_quiet", 32'(nstr), 32'd0);
      step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
      check_val("t5_first_underrun", 32'(underrun), 32'd1);

      // Drop enable while waiting for rfd
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h300 + 16'(i), 1'b1, 1'b1);
      for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      check_val("t6_no_strobe", 32'(din_valid), 32'd0);
      first = -1; nstr = 0;
      for (int i = 1; i <= 9; i++) begin
         step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
         if (din_valid) begin
            nstr++;
            if (first < 0) first = i;
         end
      end
      check_val("t6_restart", 32'(first), 32'd9);
      check_val("t6_strobes", 32'(nstr), 32'd1);
      check_val("t6_head_kept", 32'(din), 32'h300);

      // Random traffic
      en_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) en_r = !en_r;
         step(($urandom_range(0, 199) == 0), en_r, 16'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Transmit-side streamer that feeds 16-bit audio samples into the pipelined FIR's din/rfd input at a fixed audio sample rate derived from clk.
- Buffers samples from an upstream valid/ready source in a small FIFO.
- Emits exactly one sample per sample period while the FIR signals rfd.
- Counts emitted samples and flags underruns and late (rfd-stalled) periods.
- Sits between the sample source (file/ROM/ADC front-end) and the FIR_Pipe block.

Parameters:
SAMPLE_W, 16, sample width in bits
DEPTH, 16, FIFO depth in samples (power of 2, >=2)
SAMPLE_DIV, 1134, clk cycles per sample period (20 ns clk -> 44.1 kHz)
CNT_W, 32, width of samples_sent counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
enable  in  1  run pacing; low = idle
s_data  in  SAMPLE_W  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  FIFO can accept (= !full && !rst)
rfd  in  1  FIR ready-for-data
din  out  SAMPLE_W  sample to FIR
din_valid  out  1  one-cycle strobe; din valid
underrun  out  1  sticky: period elapsed with FIFO empty
late  out  1  sticky: new tick arrived while previous still pending
samples_sent  out  CNT_W  count of din_valid strobes, wraps
underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, tick counter=0, state=IDLE. Outputs din=0, din_valid=0, underrun=0, late=0, samples_sent=0, underrun_cnt=0. Reset mid-operation discards pending samples.
- Push: s_valid && s_ready at posedge writes s_data. Push is independent of state; it is also accepted while IDLE.
- Tick counter: runs 0..SAMPLE_DIV-1 only in RUN/WAIT_RFD. tick=1 in the cycle count==SAMPLE_DIV-1; count then wraps to 0. First tick occurs SAMPLE_DIV cycles after enable rises.
- FSM:
  - IDLE: enable=1 -> RUN.
  - RUN: on tick with rfd=1 -> emit and stay in RUN. On tick with rfd=0 -> WAIT_RFD.
  - WAIT_RFD: first cycle with rfd=1 -> emit, then RUN. If another tick occurs while still waiting -> set late, stay in WAIT_RFD; the ticks merge and only one emit follows.
  - Any state: enable=0 -> IDLE, count=0, pending dropped. FIFO contents are retained.
- Emit (registered, 1-cycle latency from the deciding edge): din_valid=1 for exactly one cycle; samples_sent+1.
  - FIFO non-empty: din=FIFO head, pop.
  - FIFO empty: din=0, set underrun, underrun_cnt+1 (saturates at 0xFFFF).
  - A push in the same cycle as an empty-FIFO emit does not bypass; it is still an underrun.
- din holds its last value between strobes.
- Full FIFO: s_ready=0. A pop frees a slot and s_ready rises the next cycle.
- Empty FIFO with simultaneous push and pop: not possible (no bypass).
- Sticky flags clear only on rst.

Optional Feature:
FEEDER_HOLD_LAST_EN
- Defined: on underrun, din repeats the last emitted sample (0 if none since reset). underrun and underrun_cnt still update.
- Undefined: underrun emits 0 (silence).

Decomposition:
- Package fir_feeder_pkg: SAMPLE_W, DEFAULT_SAMPLE_DIV=1134, FSM state enum {IDLE, RUN, WAIT_RFD}.
- Sub-module fir_sample_fifo: synchronous FIFO with push/pop/full/empty/head, parameterised by SAMPLE_W and DEPTH.
- Pacing counter and FSM stay in the top module.

Test Plan:
1. SAMPLE_DIV=8, rfd=1, push 0x0001..0x0004, enable -> din_valid strobes every 8 cycles, first 9 cycles after enable; din=1,2,3,4; samples_sent=4.
2. FIFO empty, enable 3 periods -> three strobes with din=0x0000, underrun=1, underrun_cnt=3. With FEEDER_HOLD_LAST_EN after prior 0x1234: din=0x1234 x3.
3. Push 17 samples with DEPTH=16, enable=0 -> s_ready low after the 16th push; the 17th is accepted only after the first emit pops.
4. rfd=0 at tick, raised 3 cycles later -> single strobe the cycle after rfd rises; late=0. Hold rfd=0 across 2 ticks -> late=1, one strobe only.
5. rst pulsed mid-run with 5 samples queued -> all outputs 0, FIFO empty, no strobe for SAMPLE_DIV cycles after re-enable.
6. Drop enable while in WAIT_RFD -> no strobe; FIFO count unchanged; re-enable restarts the period from 0.
